// File: rtl/tile_buf_pkg.sv
// rtl/tile_buf_pkg.sv - shared tile types, width helpers and address map for tile_stream_buffer
package tile_buf_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_TILE_ELEMS   = 32;
    localparam int DEF_TILE_WIDTH   = DEF_DATA_WIDTH * DEF_TILE_ELEMS;
    localparam int DEF_BUFFER_COUNT = 32;
    localparam int DEF_DEPTH_TILES  = 32;

    typedef logic [DEF_TILE_WIDTH-1:0]        tile_t;
    typedef logic signed [DEF_DATA_WIDTH-1:0] elem_t;

    function automatic int id_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Needs to hold DEPTH_TILES itself, not just DEPTH_TILES-1.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned tile_addr(input int unsigned id,
                                              input int unsigned idx,
                                              input int unsigned depth);
        return id * depth + idx;
    endfunction

endpackage

// File: rtl/tile_buf_mem.sv
// rtl/tile_buf_mem.sv - simple dual-port tile store, 1-cycle registered read, read-before-write
module tile_buf_mem #(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value between reads; contents of store are never reset.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = store[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tile_stream_buffer.sv
// rtl/tile_stream_buffer.sv - multi-buffer tile store with fill tracking and stalling streaming reads
// Optional TILE_BUF_RANDOM_RD_EN adds rd_rand/rd_idx random-index reads.
module tile_stream_buffer
    import tile_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int TILE_ELEMS   = DEF_TILE_ELEMS,
    parameter int TILE_WIDTH   = DATA_WIDTH * TILE_ELEMS,
    parameter int BUFFER_COUNT = DEF_BUFFER_COUNT,
    parameter int DEPTH_TILES  = DEF_DEPTH_TILES,
    parameter int WRITE_WRAP   = 0,
    parameter int ID_W         = id_width(BUFFER_COUNT),
    parameter int LEN_W        = len_width(DEPTH_TILES)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ID_W-1:0]              wr_id,
    input  logic [TILE_WIDTH-1:0]        wr_data,
    input  logic                         wr_last,
    output logic                         wr_done,
    output logic [ID_W-1:0]              wr_done_id,
    input  logic                         rd_req,
    output logic                         rd_ready,
    input  logic [ID_W-1:0]              rd_id,
`ifdef TILE_BUF_RANDOM_RD_EN
    input  logic                         rd_rand,
    input  logic [LEN_W-1:0]             rd_idx,
`endif
    output logic signed [DATA_WIDTH-1:0] rd_data [0:TILE_ELEMS-1],
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic                         rd_done,
    input  logic                         rewind_valid,
    input  logic [ID_W-1:0]              rewind_id,
    input  logic [ID_W-1:0]              status_id,
    output logic [LEN_W-1:0]             status_len,
    output logic                         status_sealed
);

    localparam int               ENTRIES  = BUFFER_COUNT * DEPTH_TILES;
    localparam int               ADDR_W   = id_width(ENTRIES);
    localparam logic [ID_W:0]    BUF_LIM  = (ID_W+1)'(BUFFER_COUNT);
    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH_TILES);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH_TILES - 1);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

    logic [LEN_W-1:0]        wr_ptr_q [BUFFER_COUNT];
    logic [LEN_W-1:0]        wr_ptr_d [BUFFER_COUNT];
    logic [LEN_W-1:0]        len_q    [BUFFER_COUNT];
    logic [LEN_W-1:0]        len_d    [BUFFER_COUNT];
    logic [LEN_W-1:0]        rd_ptr_q [BUFFER_COUNT];
    logic [LEN_W-1:0]        rd_ptr_d [BUFFER_COUNT];
    logic [BUFFER_COUNT-1:0] sealed_q;
    logic [BUFFER_COUNT-1:0] sealed_d;

    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            wr_done_q, wr_done_d;
    logic [ID_W-1:0] wr_done_id_q, wr_done_id_d;

    logic wr_id_ok, rd_id_ok, rewind_id_ok, status_id_ok;
    logic wr_fire, rd_fire, rd_advance, rd_is_last;
    logic [LEN_W-1:0]      wr_idx;
    logic [LEN_W-1:0]      rd_idx_sel;
    logic [LEN_W-1:0]      rd_len;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [ADDR_W-1:0]     mem_raddr;
    logic [TILE_WIDTH-1:0] mem_rdata;

    assign wr_id_ok     = {1'b0, wr_id} < BUF_LIM;
    assign rd_id_ok     = {1'b0, rd_id} < BUF_LIM;
    assign rewind_id_ok = {1'b0, rewind_id} < BUF_LIM;
    assign status_id_ok = {1'b0, status_id} < BUF_LIM;

    // A sealed buffer always accepts: the beat opens a new frame at tile 0.
    assign wr_ready = wr_id_ok & (sealed_q[wr_id] | (WRITE_WRAP != 0) | (wr_ptr_q[wr_id] < DEPTH_L));
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_idx   = sealed_q[wr_id] ? '0 : wr_ptr_q[wr_id];

`ifdef TILE_BUF_RANDOM_RD_EN
    assign rd_idx_sel = rd_rand ? rd_idx : rd_ptr_q[rd_id];
    assign rd_advance = rd_fire & ~rd_rand;
`else
    assign rd_idx_sel = rd_ptr_q[rd_id];
    assign rd_advance = rd_fire;
`endif

    // Registered len only, so a tile becomes readable the cycle after it is written.
    assign rd_len     = len_q[rd_id];
    assign rd_ready   = rd_id_ok & (rd_idx_sel < rd_len);
    assign rd_fire    = rd_req & rd_ready;
    assign rd_is_last = (rd_idx_sel == (rd_len - ONE_L));

    assign mem_waddr = ADDR_W'(tile_addr(32'(wr_id), 32'(wr_idx), DEPTH_TILES));
    assign mem_raddr = ADDR_W'(tile_addr(32'(rd_id), 32'(rd_idx_sel), DEPTH_TILES));

    // Write, then read, then rewind: later updates win on the same buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        sealed_d = sealed_q;
        if (wr_fire) begin
            if (sealed_q[wr_id]) begin
                wr_ptr_d[wr_id] = ONE_L;
                len_d[wr_id]    = ONE_L;
                rd_ptr_d[wr_id] = '0;
                sealed_d[wr_id] = 1'b0;
            end else begin
                wr_ptr_d[wr_id] = ((WRITE_WRAP != 0) && (wr_ptr_q[wr_id] == LAST_IDX))
                                ? '0 : wr_ptr_q[wr_id] + ONE_L;
                len_d[wr_id]    = (len_q[wr_id] == DEPTH_L) ? DEPTH_L : len_q[wr_id] + ONE_L;
            end
            if (wr_last) begin
                sealed_d[wr_id] = 1'b1;
            end
        end
        if (rd_advance) begin
            rd_ptr_d[rd_id] = rd_is_last ? '0 : rd_ptr_q[rd_id] + ONE_L;
        end
        if (rewind_valid && rewind_id_ok) begin
            rd_ptr_d[rewind_id] = '0;
        end
    end

    always_comb begin
        rd_valid_d   = rd_fire;
        rd_last_d    = rd_fire & rd_is_last;
        wr_done_d    = wr_fire & wr_last;
        wr_done_id_d = wr_done_d ? wr_id : wr_done_id_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '{default: '0};
            len_q        <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            sealed_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_done_id_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            sealed_q     <= sealed_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            wr_done_q    <= wr_done_d;
            wr_done_id_q <= wr_done_id_d;
        end
    end

    tile_buf_mem #(
        .WIDTH  (TILE_WIDTH),
        .DEPTH  (ENTRIES),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_fire),
        .wr_addr (mem_waddr),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (mem_raddr),
        .rd_data (mem_rdata)
    );

    for (genvar i = 0; i < TILE_ELEMS; i++) begin : g_unpack
        assign rd_data[i] = mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign rd_valid      = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign rd_done       = rd_valid_q & rd_last_q;
    assign wr_done       = wr_done_q;
    assign wr_done_id    = wr_done_id_q;
    assign status_len    = status_id_ok ? len_q[status_id] : '0;
    assign status_sealed = status_id_ok & sealed_q[status_id];

endmodule

// File: tb/tb_tile_stream_buffer.sv
// tb/tb_tile_stream_buffer.sv - directed self-checking bench for tile_stream_buffer (backpressure and wrap instances)
module tb_tile_stream_buffer;
    import tile_buf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        wr_valid, wr_last, rd_req, rewind_valid;
    logic [1:0]  wr_id, rd_id, rewind_id, status_id;
    tile_t       wr_data;
`ifdef TILE_BUF_RANDOM_RD_EN
    logic        rd_rand;
    logic [3:0]  rd_idx;
`endif

    logic        wr_ready, wr_done, rd_ready, rd_valid, rd_last, rd_done, status_sealed;
    logic [1:0]  wr_done_id;
    logic [3:0]  status_len;
    elem_t       rd_data [0:31];
    logic        w_wr_ready, w_wr_done, w_rd_ready, w_rd_valid, w_rd_last, w_rd_done, w_status_sealed;
    logic [1:0]  w_wr_done_id;
    logic [3:0]  w_status_len;
    elem_t       w_rd_data [0:31];

    tile_t rd_tile, w_rd_tile;
    int    n_checks = 0;
    int    n_errors = 0;

    tile_stream_buffer #(.BUFFER_COUNT(4), .DEPTH_TILES(8), .WRITE_WRAP(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_data(wr_data), .wr_last(wr_last),
        .wr_done(wr_done), .wr_done_id(wr_done_id),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_id(rd_id),
`ifdef TILE_BUF_RANDOM_RD_EN
        .rd_rand(rd_rand), .rd_idx(rd_idx),
`endif
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_done(rd_done),
        .rewind_valid(rewind_valid), .rewind_id(rewind_id),
        .status_id(status_id), .status_len(status_len), .status_sealed(status_sealed)
    );

    tile_stream_buffer #(.BUFFER_COUNT(4), .DEPTH_TILES(8), .WRITE_WRAP(1)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(w_wr_ready), .wr_id(wr_id), .wr_data(wr_data), .wr_last(wr_last),
        .wr_done(w_wr_done), .wr_done_id(w_wr_done_id),
        .rd_req(rd_req), .rd_ready(w_rd_ready), .rd_id(rd_id),
`ifdef TILE_BUF_RANDOM_RD_EN
        .rd_rand(rd_rand), .rd_idx(rd_idx),
`endif
        .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_last(w_rd_last), .rd_done(w_rd_done),
        .rewind_valid(rewind_valid), .rewind_id(rewind_id),
        .status_id(status_id), .status_len(w_status_len), .status_sealed(w_status_sealed)
    );

    always_comb begin
        rd_tile   = '0;
        w_rd_tile = '0;
        for (int i = 0; i < 32; i++) begin
            rd_tile[i*8 +: 8]   = rd_data[i];
            w_rd_tile[i*8 +: 8] = w_rd_data[i];
        end
    end

    function automatic tile_t pat(input int k);
        tile_t t;
        for (int i = 0; i < 32; i++) t[i*8 +: 8] = 8'(k * 37 + i);
        return t;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tile(input logic [1:0] id, input tile_t data, input logic last);
        wr_valid = 1'b1; wr_id = id; wr_data = data; wr_last = last;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic read_tile(input string tag, input logic [1:0] id, input tile_t exp, input logic exp_last);
        rd_req = 1'b1; rd_id = id;
        #1;
        check({tag, "_rdy"}, rd_ready, 1);
        tick();
        rd_req = 1'b0;
        check({tag, "_vld"}, rd_valid, 1);
        check({tag, "_dat"}, rd_tile, exp);
        check({tag, "_last"}, rd_last, exp_last);
        check({tag, "_done"}, rd_done, exp_last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; rd_req = 1'b0; rewind_valid = 1'b0;
        wr_id = '0; rd_id = '0; rewind_id = '0; status_id = '0; wr_data = '0;
`ifdef TILE_BUF_RANDOM_RD_EN
        rd_rand = 1'b0; rd_idx = '0;
`endif
        repeat (3) tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_data", rd_tile, '0);
        check("rst_len", status_len, 0);
        reset_n = 1'b1;
        tick();

        // 1: three-tile frame into buf 2, sequential reads with auto-rewind
        write_tile(2'd2, pat(1), 1'b0);
        check("t1_no_done", wr_done, 0);
        write_tile(2'd2, pat(2), 1'b0);
        write_tile(2'd2, pat(3), 1'b1);
        check("t1_wr_done", wr_done, 1);
        check("t1_wr_done_id", wr_done_id, 2);
        status_id = 2'd2;
        #1;
        check("t1_len", status_len, 3);
        check("t1_sealed", status_sealed, 1);
        read_tile("t1_r0", 2'd2, pat(1), 1'b0);
        check("t1_done_pulse", wr_done, 0);
        read_tile("t1_r1", 2'd2, pat(2), 1'b0);
        read_tile("t1_r2", 2'd2, pat(3), 1'b1);
        read_tile("t1_r3", 2'd2, pat(1), 1'b0);
        tick();
        check("t1_idle_vld", rd_valid, 0);
        check("t1_hold_dat", rd_tile, pat(1));
        rewind_valid = 1'b1; rewind_id = 2'd2;
        tick();
        rewind_valid = 1'b0;
        read_tile("t1_rew", 2'd2, pat(1), 1'b0);

        // 2: read stalls until the tile is written, no bypass
        rd_req = 1'b1; rd_id = 2'd1;
        #1;
        check("t2_empty_rdy", rd_ready, 0);
        wr_valid = 1'b1; wr_id = 2'd1; wr_data = pat(5); wr_last = 1'b0;
        #1;
        check("t2_same_cyc_rdy", rd_ready, 0);
        tick();
        wr_valid = 1'b0;
        check("t2_n1_rdy", rd_ready, 1);
        check("t2_n1_vld", rd_valid, 0);
        tick();
        rd_req = 1'b0;
        check("t2_n2_vld", rd_valid, 1);
        check("t2_n2_dat", rd_tile, pat(5));
        check("t2_n2_last", rd_last, 1);

        // 3: fill buf 0; backpressure instance stalls, wrap instance overwrites tile 0
        for (int i = 0; i < 8; i++) write_tile(2'd0, pat(10 + i), 1'b0);
        wr_valid = 1'b1; wr_id = 2'd0; wr_data = pat(20);
        #1;
        check("t3_full_rdy", wr_ready, 0);
        check("t3_wrap_rdy", w_wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        status_id = 2'd0;
        #1;
        check("t3_len", status_len, 8);
        check("t3_wrap_len", w_status_len, 8);
        check("t3_still_full", wr_ready, 0);
        rd_req = 1'b1; rd_id = 2'd0;
        tick();
        rd_req = 1'b0;
        check("t3_rd_dat", rd_tile, pat(10));
        check("t3_wrap_dat", w_rd_tile, pat(20));
        check("t3_wrap_vld", w_rd_valid, 1);

        // 4: new frame on a sealed, partly read buffer
        for (int i = 0; i < 4; i++) write_tile(2'd3, pat(30 + i), i == 3);
        read_tile("t4_r0", 2'd3, pat(30), 1'b0);
        read_tile("t4_r1", 2'd3, pat(31), 1'b0);
        write_tile(2'd3, pat(40), 1'b0);
        status_id = 2'd3;
        #1;
        check("t4_len", status_len, 1);
        check("t4_sealed", status_sealed, 0);
        read_tile("t4_x", 2'd3, pat(40), 1'b1);

        // 5: asynchronous reset while rd_valid is high
        rd_req = 1'b1; rd_id = 2'd2;
        tick();
        rd_req = 1'b0;
        check("t5_vld_pre", rd_valid, 1);
        check("t5_dat_pre", rd_tile, pat(2));
        reset_n = 1'b0;
        #1;
        check("t5_vld_rst", rd_valid, 0);
        check("t5_dat_rst", rd_tile, '0);
        for (int i = 0; i < 4; i++) begin
            status_id = 2'(i);
            #1;
            check("t5_len", status_len, 0);
            check("t5_wrap_len", w_status_len, 0);
            check("t5_sealed", status_sealed, 0);
        end
        tick();
        reset_n = 1'b1;
        tick();
        rd_req = 1'b1; rd_id = 2'd2;
        #1;
        check("t5_rdy_after", rd_ready, 0);
        tick();
        rd_req = 1'b0;
        check("t5_no_vld", rd_valid, 0);

`ifdef TILE_BUF_RANDOM_RD_EN
        // 6: random-index reads leave the sequential pointer alone
        for (int i = 0; i < 6; i++) write_tile(2'd1, pat(50 + i), 1'b0);
        rd_req = 1'b1; rd_id = 2'd1; rd_rand = 1'b1; rd_idx = 4'd5;
        #1;
        check("t6_rand_rdy", rd_ready, 1);
        tick();
        rd_req = 1'b0; rd_rand = 1'b0;
        check("t6_rand_dat", rd_tile, pat(55));
        check("t6_rand_last", rd_last, 1);
        read_tile("t6_seq", 2'd1, pat(50), 1'b0);
        rd_req = 1'b1; rd_rand = 1'b1; rd_idx = 4'd6;
        #1;
        check("t6_oob_rdy", rd_ready, 0);
        rd_req = 1'b0; rd_rand = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
